// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int STARVE_CNT_W = 4;

    // Who owns the read data coming back from the RAM next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    // Only fetches and loads produce read data; stores and idle cycles do not.
    function automatic owner_t next_owner(input logic if_gnt, input logic d_gnt, input logic d_we);
        if (if_gnt) begin
            return OWN_IF;
        end
        if (d_gnt && !d_we) begin
            return OWN_DATA;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared RAM port around the arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are held by the master until the matching grant.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    // data port
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // shared RAM port
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Core and RAM side: issues requests, returns RAM read data.
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive data grants while fetch waits; raises force_if at the limit.
// Latency: force_if is registered state, valid the cycle after the limit is reached.
// Backpressure: none; observes grants only. STARVE_LIMIT legal range is 1..15.
module mem_arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic force_if
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;

    // Count data wins over a waiting fetch; any fetch grant or idle fetch clears.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_if = (starve_cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync RAM between fetch and data ports; optional MEM_ARB_PERF_EN stall counters.
// Latency: grant and RAM access same cycle; read data returns one cycle after grant, tagged to owner.
// Backpressure: one grant per cycle, data first unless fetch has waited STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_if_stall,
    output logic [31:0]          perf_d_stall
`endif
);

    logic   if_gnt;
    logic   d_gnt;
    logic   force_if;
    owner_t rd_owner_q;
    owner_t rd_owner_d;

    mem_arb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (bus.if_req),
        .if_gnt   (if_gnt),
        .d_gnt    (d_gnt),
        .force_if (force_if)
    );

    // Grant selection: lone requester wins, data wins ties unless fetch is being starved.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (bus.if_req && (!bus.d_req || force_if)) begin
                if_gnt = 1'b1;
            end else if (bus.d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // RAM port mirrors whichever requester holds the grant; quiet when nobody does.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (if_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr;
        end else if (d_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_be;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Tag the read issued this cycle so next cycle's RAM data goes to its owner.
    always_comb begin
        rd_owner_d = next_owner(if_gnt, d_gnt, bus.d_we);
    end

    // Owner register; reset drops any read in flight so it never returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = (rd_owner_q == OWN_IF);
    assign bus.d_rvalid  = (rd_owner_q == OWN_DATA);
    assign bus.if_rdata  = (rd_owner_q == OWN_IF)   ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (rd_owner_q == OWN_DATA) ? bus.mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_q;
    logic [31:0] perf_if_stall_d;
    logic [31:0] perf_d_stall_q;
    logic [31:0] perf_d_stall_d;

    // Stall counters: one tick per cycle a port requests without a grant; wrap freely.
    always_comb begin
        perf_if_stall_d = perf_if_stall_q + 32'(bus.if_req && !if_gnt);
        perf_d_stall_d  = perf_d_stall_q  + 32'(bus.d_req && !d_gnt);
    end

    // Stall counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_if_stall_q <= '0;
            perf_d_stall_q  <= '0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_d_stall_q  <= perf_d_stall_d;
        end
    end

    assign perf_if_stall = perf_if_stall_q;
    assign perf_d_stall  = perf_d_stall_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port and the data (load/store) port of the 5-stage RV32I core.
- Sits between the core and the memory macro, replacing the current separate instruction and data buses.
- Data side has fixed priority; a starvation guard guarantees fetch forward progress.
- Read data returns one cycle after grant, tagged to its owner.

Parameters:
ADDR_W, 10, word-address width of the shared RAM
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive data grants while fetch is waiting (legal range 1..15)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_be  in  4  byte enables for store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  d_rdata valid (loads only)
d_rdata  out  DATA_W  load data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_be  out  4  RAM byte write mask
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Grants are combinational from the requests and registered state. At most one grant per cycle.
- Mem outputs combinationally mirror the granted requester. With no grant: mem_en=0, mem_we=0, all other mem_* outputs 0.
- Arbitration order:
  - If only one requester is active, it wins.
  - If both are active, data wins unless starve_cnt == STARVE_LIMIT; then fetch wins.
- starve_cnt (4-bit):
  - Increments when d_gnt && if_req.
  - Clears when if_gnt, or when if_req=0.
  - Saturates at STARVE_LIMIT.
- Read return tracking: rd_owner register with states NONE, IF, DATA.
  - Each cycle rd_owner loads IF on a fetch grant, DATA on a load grant, and NONE otherwise (including store grants).
  - if_rvalid = (rd_owner==IF). d_rvalid = (rd_owner==DATA).
  - Both rdata outputs are driven from mem_rdata, and gated to 0 when their rvalid is low.
- Latency:
  - Grant is in cycle N.
  - Load and fetch data are returned in cycle N+1.
  - A store completes in cycle N, with no response.
- Back-to-back grants every cycle are legal; rd_owner pipelines correctly with no bubble.
- A store with d_be=4'b0000 is granted, with mem_en=1 and mem_we=1, and leaves memory unchanged.
- Dropping a request before its grant is illegal. The arbiter does not check for it; the bench asserts on it.
- Reset (rst_n=0 sampled at a rising edge):
  - rd_owner=NONE and starve_cnt=0.
  - All grants and mem_* outputs are forced to 0 while rst_n=0.
  - A read granted in the cycle before reset produces no rvalid.
- Registered outputs after reset: if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0.

Optional Feature:
MEM_ARB_PERF_EN
- Defined:
  - Adds outputs perf_if_stall[31:0] and perf_d_stall[31:0].
  - perf_if_stall increments each cycle with if_req && !if_gnt; perf_d_stall increments each cycle with d_req && !d_gnt.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: the ports and logic are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package mem_arb_pkg holds:
  - owner_t enum (OWN_NONE, OWN_IF, OWN_DATA).
  - Default width constants ADDR_W_DEF=10 and DATA_W_DEF=32.
  - STARVE_CNT_W=4.
- One sub-module, mem_arb_starve_guard:
  - Inputs: if_req, if_gnt, d_gnt.
  - Output: force_if.
  - Holds starve_cnt and the saturation compare.
- Top level holds the grant mux, rd_owner, response gating and the optional perf counters.

Test Plan:
- Fetch only: if_req=1, addr 0x004, RAM[4]=0x00500093 → if_gnt same cycle; if_rvalid=1 and if_rdata=0x00500093 next cycle; d_rvalid=0.
- Store then load: d_we=1, be=4'b0011, addr 0x010, wdata 0xAABBCCDD onto RAM 0x11223344; then a load of 0x010 → d_rvalid one cycle after the load grant; d_rdata=0x1122CCDD.
- Contention: both requests held continuously, STARVE_LIMIT=4 → grant pattern D,D,D,D,IF repeating; if_rvalid exactly one cycle after each IF grant.
- Back-to-back reads: alternating single-cycle load and fetch grants → rvalid owner tracks each grant with no gaps and no cross-delivery of data.
- Reset mid-read: load granted in cycle N, rst_n=0 at edge N+1 → d_rvalid stays 0; starve_cnt=0; first grant after reset follows the no-history priority rules.
- With MEM_ARB_PERF_EN: fetch held 4 cycles behind data → perf_if_stall=4, perf_d_stall=0.
